// File: rtl/mem_access_unit.sv
// Memory-stage bus access unit: byte enables, store lanes, load extension, alignment checks and stall.
// Optional macro MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT silent cycles.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [3:0]  DataTypeM,
    input  logic [31:0] ALUResM,
    input  logic [31:0] WriteDataM,
    input  logic        ExcOccurM,
    input  logic [4:0]  ExcCodeM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        ExcOccurOut,
    output logic [4:0]  ExcCodeOut,
    output logic [31:0] BadVAddrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic        isWord, isHalf, isByte, isMem;
    logic        misalign, acc, timeout, busFail;
    logic [3:0]  beNext;
    logic [31:0] wdataNext, rdShift, loadExt;
    logic        errQ;
    logic [31:0] badAddrQ;

    always_comb begin
        isWord   = (DataTypeM == 4'd1);
        isHalf   = (DataTypeM == 4'd2) | (DataTypeM == 4'd3);
        isByte   = (DataTypeM == 4'd4) | (DataTypeM == 4'd5);
        isMem    = (MemtoRegM | MemWriteM) & (isWord | isHalf | isByte);
        misalign = isMem & ((isWord & |ALUResM[1:0]) | (isHalf & ALUResM[0]));
        acc      = isMem & !ExcOccurM & !misalign;
    end

    always_comb begin
        beNext    = 4'b0000;
        wdataNext = WriteDataM;
        unique case (1'b1)
            isWord: beNext = 4'b1111;
            isHalf: begin
                beNext    = 4'b0011 << ALUResM[1:0];
                wdataNext = {2{WriteDataM[15:0]}};
            end
            isByte: begin
                beNext    = 4'b0001 << ALUResM[1:0];
                wdataNext = {4{WriteDataM[7:0]}};
            end
            default: beNext = 4'b0000;
        endcase
    end

    // Halfword lanes are aligned, so one shift serves both byte and half selection.
    always_comb begin
        rdShift = bus_rdata >> {ALUResM[1:0], 3'b000};
        case (DataTypeM)
            4'd2:    loadExt = {16'h0000, rdShift[15:0]};
            4'd3:    loadExt = {{16{rdShift[15]}}, rdShift[15:0]};
            4'd4:    loadExt = {24'h000000, rdShift[7:0]};
            4'd5:    loadExt = {{24{rdShift[7]}}, rdShift[7:0]};
            default: loadExt = bus_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] toCnt;

    assign timeout = (state == BUSY) & (toCnt == CntW'(TIMEOUT - 1))
                   & !bus_ack & !bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            toCnt <= '0;
        else if (state == BUSY)
            toCnt <= toCnt + 1'b1;
        else
            toCnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    assign busFail = bus_err | timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            ReadDataM <= 32'h0;
            errQ      <= 1'b0;
            badAddrQ  <= 32'h0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    state     <= BUSY;
                    bus_req   <= 1'b1;
                    bus_we    <= MemWriteM;
                    bus_be    <= beNext;
                    bus_wdata <= wdataNext;
                end
                BUSY: if (busFail) begin
                    state    <= DONE;
                    bus_req  <= 1'b0;
                    errQ     <= 1'b1;
                    badAddrQ <= ALUResM;
                end else if (bus_ack) begin
                    state   <= DONE;
                    bus_req <= 1'b0;
                    if (MemtoRegM)
                        ReadDataM <= loadExt;
                end
                DONE: begin
                    state    <= IDLE;
                    errQ     <= 1'b0;
                    badAddrQ <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_addr = {ALUResM[31:2], 2'b00};
    assign StallM   = (state == IDLE) ? acc : (state == BUSY);

    // Upstream exception beats misalignment, which beats a latched bus error.
    always_comb begin
        ExcOccurOut = ExcOccurM | misalign | errQ;
        if (ExcOccurM)
            ExcCodeOut = ExcCodeM;
        else if (misalign)
            ExcCodeOut = MemWriteM ? 5'd5 : 5'd4;
        else if (errQ)
            ExcCodeOut = 5'd7;
        else
            ExcCodeOut = 5'd0;
        BadVAddrM = (!ExcOccurM && misalign) ? ALUResM : badAddrQ;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Timeout scenario runs only when MEM_TIMEOUT_EN is defined (TIMEOUT = 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegM, MemWriteM, ExcOccurM;
    logic [3:0]  DataTypeM;
    logic [31:0] ALUResM, WriteDataM;
    logic [4:0]  ExcCodeM;
    logic        StallM, ExcOccurOut;
    logic [31:0] ReadDataM, BadVAddrM;
    logic [4:0]  ExcCodeOut;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .DataTypeM(DataTypeM), .ALUResM(ALUResM),
        .WriteDataM(WriteDataM), .ExcOccurM(ExcOccurM),
        .ExcCodeM(ExcCodeM), .StallM(StallM),
        .ReadDataM(ReadDataM), .ExcOccurOut(ExcOccurOut),
        .ExcCodeOut(ExcCodeOut), .BadVAddrM(BadVAddrM),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic clear_inputs;
        MemtoRegM = 0; MemWriteM = 0; DataTypeM = 0;
        ALUResM = 0; WriteDataM = 0;
        ExcOccurM = 0; ExcCodeM = 0;
    endtask

    // Load with bus_ack in the first BUSY cycle; returns ReadDataM in DONE.
    task automatic do_load(input logic [3:0] dt, input logic [31:0] addr,
                           input logic [31:0] rd,
                           output logic [31:0] data, output logic [3:0] be);
        @(negedge clk);
        MemtoRegM = 1; MemWriteM = 0; DataTypeM = dt; ALUResM = addr;
        @(negedge clk);
        be = bus_be; bus_ack = 1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 0; data = ReadDataM;
        clear_inputs();
    endtask

    task automatic test_reset;
        clear_inputs();
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        reset = 1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (StallM !== 1'b0) begin nFails++;
            $display("FAIL rst_stall: got %b want 0", StallM); end
        nChecks++;
        if (bus_req !== 1'b0) begin nFails++;
            $display("FAIL rst_req: got %b want 0", bus_req); end
        nChecks++;
        if ({bus_we, bus_be, bus_wdata} !== 37'h0) begin nFails++;
            $display("FAIL rst_bus: got we=%b be=%b wd=%h want 0",
                     bus_we, bus_be, bus_wdata); end
        nChecks++;
        if ({ReadDataM, BadVAddrM} !== 64'h0) begin nFails++;
            $display("FAIL rst_data: got rd=%h bad=%h want 0", ReadDataM, BadVAddrM); end
        nChecks++;
        if (ExcOccurOut !== 1'b0) begin nFails++;
            $display("FAIL rst_exc: got %b want 0", ExcOccurOut); end
        reset = 0;
    endtask

    task automatic test_word_load;
        int stallCnt = 0;
        @(negedge clk);
        MemtoRegM = 1; DataTypeM = 1; ALUResM = 32'h10; #1;
        stallCnt += int'(StallM);
        nChecks++;
        if (bus_req !== 1'b0) begin nFails++;
            $display("FAIL wl_idle_req: got %b want 0", bus_req); end
        @(negedge clk);
        stallCnt += int'(StallM);
        nChecks++;
        if ({bus_req, bus_we, bus_be} !== 6'b101111) begin nFails++;
            $display("FAIL wl_busy: got req=%b we=%b be=%b want 1 0 1111",
                     bus_req, bus_we, bus_be); end
        nChecks++;
        if (bus_addr !== 32'h10) begin nFails++;
            $display("FAIL wl_addr: got %h want 00000010", bus_addr); end
        @(negedge clk);
        stallCnt += int'(StallM);
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_ack = 0;
        stallCnt += int'(StallM);
        nChecks++;
        if (stallCnt !== 3) begin nFails++;
            $display("FAIL wl_stall_cycles: got %0d want 3", stallCnt); end
        nChecks++;
        if (ReadDataM !== 32'hDEADBEEF) begin nFails++;
            $display("FAIL wl_data: got %h want deadbeef", ReadDataM); end
        nChecks++;
        if ({bus_req, ExcOccurOut} !== 2'b00) begin nFails++;
            $display("FAIL wl_done: got req=%b exc=%b want 0 0", bus_req, ExcOccurOut); end
        clear_inputs();
    endtask

    task automatic test_load_ext;
        logic [31:0] d;
        logic [3:0]  be;
        do_load(4'd5, 32'h13, 32'h80FF7F01, d, be);
        nChecks++;
        if (be !== 4'b1000) begin nFails++;
            $display("FAIL lb_be: got %b want 1000", be); end
        nChecks++;
        if (d !== 32'hFFFFFF80) begin nFails++;
            $display("FAIL lb_signed: got %h want ffffff80", d); end
        do_load(4'd4, 32'h13, 32'h80FF7F01, d, be);
        nChecks++;
        if (d !== 32'h00000080) begin nFails++;
            $display("FAIL lbu: got %h want 00000080", d); end
        do_load(4'd5, 32'h11, 32'h80FF7F01, d, be);
        nChecks++;
        if ({be, d} !== {4'b0010, 32'h0000007F}) begin nFails++;
            $display("FAIL lb_lane1: got be=%b d=%h want 0010 0000007f", be, d); end
        do_load(4'd3, 32'h12, 32'h80FF7F01, d, be);
        nChecks++;
        if ({be, d} !== {4'b1100, 32'hFFFF80FF}) begin nFails++;
            $display("FAIL lh_signed: got be=%b d=%h want 1100 ffff80ff", be, d); end
        do_load(4'd2, 32'h10, 32'h80FF7F01, d, be);
        nChecks++;
        if ({be, d} !== {4'b0011, 32'h00007F01}) begin nFails++;
            $display("FAIL lhu: got be=%b d=%h want 0011 00007f01", be, d); end
    endtask

    task automatic test_store;
        @(negedge clk);
        MemWriteM = 1; DataTypeM = 2; ALUResM = 32'h2; WriteDataM = 32'h12345678;
        @(negedge clk);
        nChecks++;
        if ({bus_req, bus_we, bus_be} !== 6'b111100) begin nFails++;
            $display("FAIL sh_ctl: got req=%b we=%b be=%b want 1 1 1100",
                     bus_req, bus_we, bus_be); end
        nChecks++;
        if ({bus_wdata, bus_addr} !== {32'h56785678, 32'h0}) begin nFails++;
            $display("FAIL sh_data: got wd=%h addr=%h want 56785678 00000000",
                     bus_wdata, bus_addr); end
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        nChecks++;
        if ({StallM, bus_req} !== 2'b00) begin nFails++;
            $display("FAIL sh_done: got stall=%b req=%b want 0 0", StallM, bus_req); end
        MemWriteM = 1; DataTypeM = 4; ALUResM = 32'h25; WriteDataM = 32'h000000AB;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if ({bus_be, bus_wdata} !== {4'b0010, 32'hABABABAB}) begin nFails++;
            $display("FAIL sb: got be=%b wd=%h want 0010 abababab", bus_be, bus_wdata); end
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        clear_inputs();
    endtask

    task automatic test_misalign;
        @(negedge clk);
        MemtoRegM = 1; DataTypeM = 1; ALUResM = 32'h6; #1;
        nChecks++;
        if ({ExcOccurOut, ExcCodeOut} !== {1'b1, 5'd4}) begin nFails++;
            $display("FAIL mis_adel: got exc=%b code=%0d want 1 4", ExcOccurOut, ExcCodeOut); end
        nChecks++;
        if (BadVAddrM !== 32'h6) begin nFails++;
            $display("FAIL mis_badva: got %h want 00000006", BadVAddrM); end
        @(negedge clk);
        nChecks++;
        if ({bus_req, StallM} !== 2'b00) begin nFails++;
            $display("FAIL mis_nobus: got req=%b stall=%b want 0 0", bus_req, StallM); end
        ExcOccurM = 1; ExcCodeM = 5'd10; #1;
        nChecks++;
        if ({ExcOccurOut, ExcCodeOut} !== {1'b1, 5'd10}) begin nFails++;
            $display("FAIL mis_upstream: got exc=%b code=%0d want 1 10",
                     ExcOccurOut, ExcCodeOut); end
        clear_inputs();
        MemWriteM = 1; DataTypeM = 3; ALUResM = 32'h5; #1;
        nChecks++;
        if ({ExcOccurOut, ExcCodeOut, StallM} !== {1'b1, 5'd5, 1'b0}) begin nFails++;
            $display("FAIL mis_ades: got exc=%b code=%0d stall=%b want 1 5 0",
                     ExcOccurOut, ExcCodeOut, StallM); end
        clear_inputs();
    endtask

    task automatic test_bus_error;
        @(negedge clk);
        MemWriteM = 1; DataTypeM = 1; ALUResM = 32'h20; WriteDataM = 32'hCAFE0001;
        @(negedge clk);
        bus_err = 1;
        @(negedge clk);
        bus_err = 0;
        nChecks++;
        if ({ExcOccurOut, ExcCodeOut, StallM} !== {1'b1, 5'd7, 1'b0}) begin nFails++;
            $display("FAIL berr_code: got exc=%b code=%0d stall=%b want 1 7 0",
                     ExcOccurOut, ExcCodeOut, StallM); end
        nChecks++;
        if (BadVAddrM !== 32'h20) begin nFails++;
            $display("FAIL berr_badva: got %h want 00000020", BadVAddrM); end
        clear_inputs();
        @(negedge clk);
        nChecks++;
        if (ExcOccurOut !== 1'b0) begin nFails++;
            $display("FAIL berr_clear: got %b want 0", ExcOccurOut); end
        MemtoRegM = 1; DataTypeM = 1; ALUResM = 32'h30;
        @(negedge clk);
        bus_err = 1; bus_ack = 1; bus_rdata = 32'h55555555;
        @(negedge clk);
        bus_err = 0; bus_ack = 0;
        nChecks++;
        if ({ExcOccurOut, ExcCodeOut, BadVAddrM} !== {1'b1, 5'd7, 32'h30}) begin nFails++;
            $display("FAIL berr_wins: got exc=%b code=%0d bad=%h want 1 7 00000030",
                     ExcOccurOut, ExcCodeOut, BadVAddrM); end
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        MemtoRegM = 1; DataTypeM = 1; ALUResM = 32'h40;
        @(negedge clk);
        bus_ack = 1; bus_rdata = 32'h11112222;
        @(negedge clk);
        bus_ack = 0;
        ALUResM = 32'h44; #1;
        nChecks++;
        if ({StallM, ReadDataM} !== {1'b0, 32'h11112222}) begin nFails++;
            $display("FAIL b2b_done1: got stall=%b rd=%h want 0 11112222", StallM, ReadDataM); end
        @(negedge clk);
        nChecks++;
        if ({StallM, bus_req} !== 2'b10) begin nFails++;
            $display("FAIL b2b_idle: got stall=%b req=%b want 1 0", StallM, bus_req); end
        @(negedge clk);
        nChecks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h44}) begin nFails++;
            $display("FAIL b2b_busy: got req=%b addr=%h want 1 00000044", bus_req, bus_addr); end
        bus_ack = 1; bus_rdata = 32'h33334444;
        @(negedge clk);
        bus_ack = 0;
        nChecks++;
        if (ReadDataM !== 32'h33334444) begin nFails++;
            $display("FAIL b2b_data2: got %h want 33334444", ReadDataM); end
        clear_inputs();
    endtask

    task automatic test_reset_busy;
        logic [31:0] d;
        logic [3:0]  be;
        @(negedge clk);
        MemtoRegM = 1; DataTypeM = 1; ALUResM = 32'h50;
        @(negedge clk);
        nChecks++;
        if (bus_req !== 1'b1) begin nFails++;
            $display("FAIL rb_req_before: got %b want 1", bus_req); end
        reset = 1; clear_inputs(); #1;
        nChecks++;
        if ({bus_req, StallM, ReadDataM} !== {2'b00, 32'h0}) begin nFails++;
            $display("FAIL rb_abort: got req=%b stall=%b rd=%h want 0 0 0",
                     bus_req, StallM, ReadDataM); end
        @(negedge clk);
        reset = 0;
        do_load(4'd1, 32'h8, 32'h01234567, d, be);
        nChecks++;
        if (d !== 32'h01234567) begin nFails++;
            $display("FAIL rb_after: got %h want 01234567", d); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int stallCnt = 0;
        @(negedge clk);
        MemtoRegM = 1; DataTypeM = 1; ALUResM = 32'h60;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stallCnt += int'(StallM);
        end
        @(negedge clk);
        nChecks++;
        if (stallCnt !== 4) begin nFails++;
            $display("FAIL to_busy_cycles: got %0d want 4", stallCnt); end
        nChecks++;
        if ({StallM, ExcOccurOut, ExcCodeOut, BadVAddrM} !== {2'b01, 5'd7, 32'h60}) begin
            nFails++;
            $display("FAIL to_done: got stall=%b exc=%b code=%0d bad=%h want 0 1 7 00000060",
                     StallM, ExcOccurOut, ExcCodeOut, BadVAddrM); end
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_word_load();
        test_load_ext();
        test_store();
        test_misalign();
        test_bus_error();
        test_back_to_back();
        test_reset_busy();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
